control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/cu_decode.sv | 25 ++
 rtl/control_unit.sv | 211 +++++++++++++++++++++
 tb/tb_control_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, state and register-select definitions
//
// Purpose : Constants and types used by control_unit and cu_decode.
// Contents: opcode constants, FSM state encoding, Rsel encodings,
//           opcode class encoding, ALU-opcode helper function.

package cpu_pkg;

    // Instruction opcodes, IR[31:27]
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Control FSM states
    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    // Register-field select driven on Rsel
    localparam logic [1:0] RSEL_NONE = 2'b00;
    localparam logic [1:0] RSEL_RA   = 2'b01;
    localparam logic [1:0] RSEL_RB   = 2'b10;
    localparam logic [1:0] RSEL_RC   = 2'b11;

    // Opcode classes produced by cu_decode
    typedef enum logic [1:0] {
        CLS_ALU     = 2'd0,
        CLS_NOP     = 2'd1,
        CLS_HALT    = 2'd2,
        CLS_ILLEGAL = 2'd3
    } op_class_t;

    function automatic logic is_alu_op(input logic [4:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_SUB) ||
               (opcode == OP_AND) || (opcode == OP_OR);
    endfunction

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational opcode classifier
//
// Purpose : Maps an instruction opcode to its class (alu/nop/halt/illegal).
// Ports   : opcode   in  5  IR[31:27]
//           op_class out 2  op_class_t encoding from cpu_pkg

module cu_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output logic [1:0] op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        if (is_alu_op(opcode)) begin
            op_class = CLS_ALU;
        end else if (opcode == OP_NOP) begin
            op_class = CLS_NOP;
        end else if (opcode == OP_HALT) begin
            op_class = CLS_HALT;
        end
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle CPU control FSM (fetch/decode/execute)
//
// Purpose : Sequences datapath enables through RST, T0..T5 and HALT.
// Ports   : Clock, Reset (sync, active-high)
//           IR[31:0]  instruction register (opcode IR[31:27])
//           MemReady  memory read data valid this cycle
//           Stop      halt request, taken at the next instruction boundary
//           PCout, Zlowout, MDRout           bus-driver enables
//           MARin, Zin, PCin, MDRin, IRin, Yin register load enables
//           IncPC, Read                      PC-increment select, read strobe
//           Rsel[1:0], Rin, Rout             register-file select and enables
//           ALUop[4:0]                       ALU operation (opcode in T4)
//           Run                              instruction executing
//           Illegal                          sticky illegal-opcode flag
// Config  : CU_ILLEGAL_TRAP_EN - when defined, unlisted opcodes trap to HALT
//           and set Illegal; otherwise they execute as nop and Illegal is 0.

module control_unit
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        MemReady,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPC,
    output logic        Read,
    output logic [1:0]  Rsel,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  ALUop,
    output logic        Run,
    output logic        Illegal
);

    state_t     state_q, state_d;
    logic       stop_pend_q, stop_pend_d;
    logic       instr_end;
    logic [4:0] opcode;
    logic [1:0] op_class_raw;
    op_class_t  op_class;

    // Register fields are consumed by the datapath, not by the sequencer.
    logic [26:0] unused_ir_fields;
    assign unused_ir_fields = IR[26:0];

    assign opcode   = IR[31:27];
    assign op_class = op_class_t'(op_class_raw);

    cu_decode u_decode (
        .opcode   (opcode),
        .op_class (op_class_raw)
    );

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_RST;
            stop_pend_q <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        instr_end = 1'b0;
        // A Stop seen in any cycle of an instruction is remembered so a
        // single-cycle pulse is still honoured at the instruction boundary.
        stop_pend_d = stop_pend_q | Stop;

        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1:  if (MemReady) state_d = ST_T2;
            ST_T2:  state_d = ST_T3;
            ST_T3: begin
                case (op_class)
                    CLS_ALU:  state_d = ST_T4;
                    CLS_HALT: state_d = ST_HALT;
                    CLS_NOP:  instr_end = 1'b1;
                    default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        state_d = ST_HALT;
`else
                        instr_end = 1'b1;
`endif
                    end
                endcase
            end
            ST_T4:  state_d = ST_T5;
            ST_T5:  instr_end = 1'b1;
            ST_HALT: begin
                state_d     = ST_HALT;
                stop_pend_d = 1'b0;
            end
            default: state_d = ST_RST;
        endcase

        if (instr_end) begin
            state_d     = (Stop || stop_pend_q) ? ST_HALT : ST_T0;
            stop_pend_d = 1'b0;
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    always_comb begin
        illegal_d = illegal_q;
        if (state_q == ST_T3 && op_class == CLS_ILLEGAL) begin
            illegal_d = 1'b1;
        end
    end
    assign Illegal = illegal_q;
`else
    assign Illegal = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Output logic: function of state and IR only
    // ---------------------------------------------------------------
    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        MARin   = 1'b0;
        Zin     = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Rsel    = RSEL_NONE;
        Rin     = 1'b0;
        Rout    = 1'b0;
        ALUop   = 5'b00000;
        Run     = 1'b0;

        case (state_q)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
                Run   = 1'b1;
            end
            ST_T1: begin
                // Held while waiting on memory; reloading PC and MDR with
                // the same values each cycle is harmless.
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                Run     = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                Run    = 1'b1;
            end
            ST_T3: begin
                Run = 1'b1;
                if (op_class == CLS_ALU) begin
                    Rsel = RSEL_RB;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end
            end
            ST_T4: begin
                Rsel  = RSEL_RC;
                Rout  = 1'b1;
                ALUop = opcode;
                Zin   = 1'b1;
                Run   = 1'b1;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                Rsel    = RSEL_RA;
                Rin     = 1'b1;
                Run     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
//
// Compile with +define+CU_ILLEGAL_TRAP_EN to check the illegal-opcode trap.

module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] IR;
    logic        MemReady;
    logic        Stop;
    logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
    logic        IncPC, Read, Rin, Rout, Run, Illegal;
    logic [1:0]  Rsel;
    logic [4:0]  ALUop;

    int n_cmp = 0;
    int n_err = 0;

    control_unit dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .IR       (IR),
        .MemReady (MemReady),
        .Stop     (Stop),
        .PCout    (PCout),
        .Zlowout  (Zlowout),
        .MDRout   (MDRout),
        .MARin    (MARin),
        .Zin      (Zin),
        .PCin     (PCin),
        .MDRin    (MDRin),
        .IRin     (IRin),
        .Yin      (Yin),
        .IncPC    (IncPC),
        .Read     (Read),
        .Rsel     (Rsel),
        .Rin      (Rin),
        .Rout     (Rout),
        .ALUop    (ALUop),
        .Run      (Run),
        .Illegal  (Illegal)
    );

    always #5 Clock = ~Clock;

    logic [21:0] obs;
    assign obs = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                  IncPC, Read, Rsel, Rin, Rout, ALUop, Run, Illegal};

    localparam logic [21:0] B_PCOUT  = 22'd1 << 21;
    localparam logic [21:0] B_ZLOW   = 22'd1 << 20;
    localparam logic [21:0] B_MDROUT = 22'd1 << 19;
    localparam logic [21:0] B_MARIN  = 22'd1 << 18;
    localparam logic [21:0] B_ZIN    = 22'd1 << 17;
    localparam logic [21:0] B_PCIN   = 22'd1 << 16;
    localparam logic [21:0] B_MDRIN  = 22'd1 << 15;
    localparam logic [21:0] B_IRIN   = 22'd1 << 14;
    localparam logic [21:0] B_YIN    = 22'd1 << 13;
    localparam logic [21:0] B_INCPC  = 22'd1 << 12;
    localparam logic [21:0] B_READ   = 22'd1 << 11;
    localparam logic [21:0] RS_RA    = 22'd1 << 9;
    localparam logic [21:0] RS_RB    = 22'd2 << 9;
    localparam logic [21:0] RS_RC    = 22'd3 << 9;
    localparam logic [21:0] B_RIN    = 22'd1 << 8;
    localparam logic [21:0] B_ROUT   = 22'd1 << 7;
    localparam logic [21:0] B_RUN    = 22'd1 << 1;
    localparam logic [21:0] B_ILL    = 22'd1;

    localparam logic [21:0] E_ZERO = 22'd0;
    localparam logic [21:0] E_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
    localparam logic [21:0] E_T1   = B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
    localparam logic [21:0] E_T2   = B_MDROUT | B_IRIN | B_RUN;
    localparam logic [21:0] E_T3A  = RS_RB | B_ROUT | B_YIN | B_RUN;
    localparam logic [21:0] E_T3N  = B_RUN;
    localparam logic [21:0] E_T5   = B_ZLOW | RS_RA | B_RIN | B_RUN;

    function automatic logic [21:0] e_t4(input logic [4:0] op);
        return RS_RC | B_ROUT | B_ZIN | B_RUN | ({17'd0, op} << 2);
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [21:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset    = 1'b1;
        IR       = 32'h0;
        MemReady = 1'b1;
        Stop     = 1'b0;

        // Reset state, then and R1,R2,R3 with memory always ready
        step(); check("reset_rst", E_ZERO);
        Reset = 1'b0;
        IR    = 32'h28918000;
        step(); check("and_t0", E_T0);
        step(); check("and_t1", E_T1);
        step(); check("and_t2", E_T2);
        step(); check("and_t3", E_T3A);
        step(); check("and_t4", e_t4(5'b00101));
        step(); check("and_t5", E_T5);
        step(); check("and_next_t0", E_T0);

        // add with MemReady low for the first three T1 cycles
        IR       = 32'h18000000;
        MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); check($sformatf("wait_t1_%0d", i), E_T1);
            if (i == 3) MemReady = 1'b1;
        end
        step(); check("wait_t2", E_T2);
        step(); check("wait_t3", E_T3A);
        step(); check("wait_t4", e_t4(5'b00011));
        step(); check("wait_t5", E_T5);
        step(); check("wait_next_t0", E_T0);

        // nop: four cycles then the next fetch
        IR = 32'hD0000000;
        step(); check("nop_t1", E_T1);
        step(); check("nop_t2", E_T2);
        step(); check("nop_t3", E_T3N);
        step(); check("nop_next_t0", E_T0);

        // sub with a one-cycle Stop pulse in T4
        IR = 32'h20000000;
        step(); check("stop_t1", E_T1);
        step(); check("stop_t2", E_T2);
        step(); check("stop_t3", E_T3A);
        step(); check("stop_t4", e_t4(5'b00100));
        Stop = 1'b1;
        step(); check("stop_t5", E_T5);
        Stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check($sformatf("stop_halt_%0d", i), E_ZERO);
        end

        // Reset out of HALT; nop with Stop at its end edge
        Reset = 1'b1;
        step(); check("rst_from_halt", E_ZERO);
        Reset = 1'b0;
        IR    = 32'hD0000000;
        step(); check("nopstop_t0", E_T0);
        step(); check("nopstop_t1", E_T1);
        step(); check("nopstop_t2", E_T2);
        step(); check("nopstop_t3", E_T3N);
        Stop = 1'b1;
        step(); check("nopstop_halt", E_ZERO);
        Stop = 1'b0;

        // halt opcode: HALT after T3, quiet for 20 cycles
        Reset = 1'b1;
        step(); check("rst_before_halt_op", E_ZERO);
        Reset = 1'b0;
        IR    = 32'hD8000000;
        step(); check("haltop_t0", E_T0);
        step(); check("haltop_t1", E_T1);
        step(); check("haltop_t2", E_T2);
        step(); check("haltop_t3", E_T3N);
        for (int i = 0; i < 20; i++) begin
            MemReady = (i % 2 == 0);
            step(); check($sformatf("haltop_hold_%0d", i), E_ZERO);
        end
        MemReady = 1'b1;

        // or, with Reset asserted during T4
        Reset = 1'b1;
        step(); check("rst_before_or", E_ZERO);
        Reset = 1'b0;
        IR    = 32'h30000000;
        step(); check("or_t0", E_T0);
        step(); check("or_t1", E_T1);
        step(); check("or_t2", E_T2);
        step(); check("or_t3", E_T3A);
        step(); check("or_t4", e_t4(5'b00110));
        Reset = 1'b1;
        step(); check("or_reset_in_t4", E_ZERO);
        Reset = 1'b0;
        step(); check("or_after_reset_t0", E_T0);

        // Unlisted opcode 11111
        IR = 32'hF8000000;
        step(); check("ill_t1", E_T1);
        step(); check("ill_t2", E_T2);
        step(); check("ill_t3", E_T3N);
`ifdef CU_ILLEGAL_TRAP_EN
        step(); check("ill_trap_halt", B_ILL);
        step(); check("ill_trap_sticky", B_ILL);
        Reset = 1'b1;
        step(); check("ill_reset_clears", E_ZERO);
        Reset = 1'b0;
        step(); check("ill_after_reset_t0", E_T0);
`else
        step(); check("ill_as_nop_t0", E_T0);
        step(); check("ill_as_nop_t1", E_T1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
